step_input_ctrl: RTL and testbench

STEP_INPUT_CTRL -- requirements
Module: step_input_ctrl

---
 rtl/mojo_pkg.sv | 23 ++
 rtl/debounce_edge.sv | 71 +++++++
 rtl/step_input_ctrl.sv | 101 ++++++++++
 tb/tb_step_input_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mojo_pkg.sv
// Shared definitions for the single-step trainer input controller:
// the capture FSM encoding, the default widths and a sizing helper for the
// debounce stability counter.
package mojo_pkg;

   localparam int WORD_W_DEF          = 8;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   // The stability counter runs 0 .. cycles-1, so it needs clog2(cycles)
   // bits, never fewer than one.
   function automatic int stab_cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/debounce_edge.sv
// Button and DIP-word front end: 2-flop synchronizers, a stability counter
// that only accepts a button level change after DEBOUNCE_CYCLES consecutive
// differing samples, and a registered one-cycle rising-edge (press) pulse.
module debounce_edge
   import mojo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int WORD_W          = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_in,
   input  logic [WORD_W-1:0] dip_in,
   output logic              btn_level,
   output logic              press,
   output logic [WORD_W-1:0] dip_sync
);

   localparam int               CNT_W  = stab_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic              btn_meta;
   logic              btn_sync;
   logic [WORD_W-1:0] dip_meta;
   logic [CNT_W-1:0]  stab_cnt;
   logic              level_d;

   // Two-stage synchronizers for the asynchronous button and switch inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         dip_meta <= '0;
         dip_sync <= '0;
      end else begin
         btn_meta <= btn_in;
         btn_sync <= btn_meta;
         dip_meta <= dip_in;
         dip_sync <= dip_meta;
      end
   end

   // Count consecutive cycles where the synchronized button disagrees with
   // the accepted level; the terminal count flips the level. Any agreeing
   // sample restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab_cnt  <= '0;
         btn_level <= 1'b0;
      end else if (btn_sync == btn_level) begin
         stab_cnt <= '0;
      end else if (stab_cnt == CNT_TC) begin
         stab_cnt  <= '0;
         btn_level <= btn_sync;
      end else begin
         stab_cnt <= stab_cnt + CNT_W'(1);
      end
   end

   // Registered rising-edge detect on the debounced level; releases are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= btn_level;
         press   <= btn_level & ~level_d;
      end
   end

endmodule

// File: rtl/step_input_ctrl.sv
// Single-step input controller: each debounced press of the activate button
// captures the DIP switch word and offers it to the CPU core with a
// valid/ready handshake. Accepted handshakes are counted, and presses that
// arrive while a word is still waiting are dropped and flagged.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no instruction waiting; instr_valid low, instr_ready ignored
// ST_PENDING | instr_out holds an unconsumed word; instr_valid high
module step_input_ctrl
   import mojo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int WORD_W          = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_in,
   input  logic [WORD_W-1:0] dip_in,
   output logic [WORD_W-1:0] instr_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        step_count,
   output logic              overrun,
   output logic              btn_level
);

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] instr_nxt;
   logic [7:0]        count_nxt;
   logic              overrun_nxt;
   logic              press;
   logic              handshake;
   logic [WORD_W-1:0] dip_sync;

   debounce_edge #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .WORD_W          (WORD_W)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .dip_in    (dip_in),
      .btn_level (btn_level),
      .press     (press),
      .dip_sync  (dip_sync)
   );

   assign instr_valid = (state == ST_PENDING);
   assign handshake   = instr_valid & instr_ready;

   // Next-state, capture and counter decisions.
   always_comb begin
      state_nxt   = state;
      instr_nxt   = instr_out;
      count_nxt   = step_count;
      overrun_nxt = overrun;
      if (handshake) begin
         count_nxt = step_count + 8'd1;
      end
      case (state)
         ST_IDLE: begin
            if (press) begin
               instr_nxt = dip_sync;
               state_nxt = ST_PENDING;
            end
         end
         ST_PENDING: begin
            // A press landing on the handshake edge is a clean hand-over,
            // not an overrun: the old word is consumed as the new one loads.
            if (handshake && press) begin
               instr_nxt = dip_sync;
            end else if (handshake) begin
               state_nxt = ST_IDLE;
            end else if (press) begin
               overrun_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, captured word, handshake counter and sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         instr_out  <= '0;
         step_count <= '0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_nxt;
         instr_out  <= instr_nxt;
         step_count <= count_nxt;
         overrun    <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_step_input_ctrl.sv
// Bench for step_input_ctrl with DEBOUNCE_CYCLES=4: directed scenarios plus
// randomized button/switch/ready traffic, all checked every cycle against a
// sample-history reference model.
module tb_step_input_ctrl;

   localparam int D = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         btn_in = 1'b0;
   logic [W-1:0] dip_in = '0;
   logic         instr_ready = 1'b0;
   logic [W-1:0] instr_out;
   logic         instr_valid;
   logic [7:0]   step_count;
   logic         overrun;
   logic         btn_level;

   int n_checks = 0;
   int n_err    = 0;

   step_input_ctrl #(.DEBOUNCE_CYCLES(D), .WORD_W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .dip_in      (dip_in),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .step_count  (step_count),
      .overrun     (overrun),
      .btn_level   (btn_level)
   );

   always #5 clk = ~clk;

   // Reference model. raw_h[i] is btn_in as sampled i edges ago; the
   // debouncer acts on samples two edges old. lvl_h[i] is the debounced
   // level after the edge i+1 edges back.
   logic         raw_h [0:D+1];
   logic [W-1:0] dip_h [0:2];
   logic         lvl_h [0:2];
   logic         m_pend;
   logic [W-1:0] m_word;
   logic [7:0]   m_cnt;
   logic         m_ovr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i <= D + 1; i++) raw_h[i] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dip_h[i] = '0;
         lvl_h[i] = 1'b0;
      end
      m_pend = 1'b0;
      m_word = '0;
      m_cnt  = '0;
      m_ovr  = 1'b0;
   endtask

   // Advance the model across one rising edge using the current inputs.
   task automatic model_edge();
      logic         flip;
      logic         prs;
      logic         hs;
      logic [W-1:0] dsync;
      if (rst) begin
         model_clear();
         return;
      end
      for (int i = D + 1; i > 0; i--) raw_h[i] = raw_h[i-1];
      raw_h[0] = btn_in;
      dip_h[2] = dip_h[1];
      dip_h[1] = dip_h[0];
      dip_h[0] = dip_in;
      dsync = dip_h[2];
      // The press seen by the FSM at this edge comes from a level rise two edges back.
      prs = lvl_h[1] & ~lvl_h[2];
      // Level flips once the last D debouncer samples all disagree with it.
      flip = 1'b1;
      for (int i = 2; i <= D + 1; i++) if (raw_h[i] == lvl_h[0]) flip = 1'b0;
      lvl_h[2] = lvl_h[1];
      lvl_h[1] = lvl_h[0];
      lvl_h[0] = flip ? ~lvl_h[1] : lvl_h[1];
      hs = m_pend & instr_ready;
      if (hs) m_cnt = m_cnt + 8'd1;
      if (prs && (!m_pend || hs)) begin
         m_word = dsync;
         m_pend = 1'b1;
      end else if (hs) begin
         m_pend = 1'b0;
      end else if (prs) begin
         m_ovr = 1'b1;
      end
   endtask

   task automatic check_all();
      chk("instr_valid", 32'(instr_valid), 32'(m_pend));
      chk("instr_out",   32'(instr_out),   32'(m_word));
      chk("step_count",  32'(step_count),  32'(m_cnt));
      chk("overrun",     32'(overrun),     32'(m_ovr));
      chk("btn_level",   32'(btn_level),   32'(lvl_h[0]));
   endtask

   int hs_seen    = 0;
   int valid_seen = 0;

   // One clock: model first, then the edge, then sample 1 ns later.
   task automatic step();
      model_edge();
      if (instr_valid && instr_ready && !rst) hs_seen++;
      @(posedge clk);
      #1;
      if (instr_valid) valid_seen++;
      check_all();
   endtask

   task automatic press(input int hi, input int lo);
      btn_in = 1'b1;
      repeat (hi) step();
      btn_in = 1'b0;
      repeat (lo) step();
   endtask

   // Assert reset mid-cycle, check outputs clear at once, hold across an edge.
   task automatic do_reset();
      #3;
      rst = 1'b1;
      #1;
      chk("rst_valid",   32'(instr_valid), 32'd0);
      chk("rst_out",     32'(instr_out),   32'd0);
      chk("rst_count",   32'(step_count),  32'd0);
      chk("rst_overrun", 32'(overrun),     32'd0);
      chk("rst_level",   32'(btn_level),   32'd0);
      model_clear();
      step();
      rst = 1'b0;
   endtask

   int first_valid;
   int run_len;
   logic [W-1:0] cap_word;

   initial begin
      model_clear();
      step();
      step();
      rst = 1'b0;
      check_all();

      // Clean press with the core ready.
      do_reset();
      dip_in = 8'hA5;
      instr_ready = 1'b1;
      valid_seen = 0;
      first_valid = 0;
      cap_word = '0;
      btn_in = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (instr_valid && first_valid == 0) begin
            first_valid = i;
            cap_word = instr_out;
         end
      end
      btn_in = 1'b0;
      repeat (12) step();
      chk("clean_latency", 32'(first_valid), 32'd8);
      chk("clean_pulses",  32'(valid_seen),  32'd1);
      chk("clean_word",    32'(cap_word),    32'hA5);
      chk("clean_count",   32'(step_count),  32'd1);
      chk("clean_overrun", 32'(overrun),     32'd0);

      // Bounce: toggle every 2 cycles, then settle low.
      do_reset();
      valid_seen = 0;
      for (int i = 0; i < 10; i++) begin
         btn_in = ~btn_in;
         repeat (2) step();
      end
      btn_in = 1'b0;
      repeat (12) step();
      chk("bounce_level", 32'(btn_level),  32'd0);
      chk("bounce_valid", 32'(valid_seen), 32'd0);

      // Backpressure: second press dropped, first word held.
      do_reset();
      instr_ready = 1'b0;
      dip_in = 8'h3C;
      press(8, 10);
      dip_in = 8'hFF;
      press(8, 10);
      chk("bp_word",    32'(instr_out),   32'h3C);
      chk("bp_overrun", 32'(overrun),     32'd1);
      chk("bp_valid",   32'(instr_valid), 32'd1);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("bp_count",      32'(step_count),  32'd1);
      chk("bp_valid_done", 32'(instr_valid), 32'd0);

      // Handshake on the same edge as the second press pulse.
      do_reset();
      instr_ready = 1'b0;
      dip_in = 8'h11;
      press(8, 10);
      dip_in = 8'h22;
      btn_in = 1'b1;
      run_len = 0;
      while (!lvl_h[0] && run_len < 30) begin
         step();
         run_len++;
      end
      chk("sim_level_timeout", 32'(run_len < 30), 32'd1);
      step();
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("sim_valid",   32'(instr_valid), 32'd1);
      chk("sim_word",    32'(instr_out),   32'h22);
      chk("sim_overrun", 32'(overrun),     32'd0);
      chk("sim_count",   32'(step_count),  32'd1);
      btn_in = 1'b0;
      repeat (10) step();

      // Reset while pending, then a normal press.
      do_reset();
      dip_in = 8'h5A;
      press(8, 4);
      chk("rm_pending", 32'(instr_valid), 32'd1);
      do_reset();
      dip_in = 8'hC3;
      instr_ready = 1'b1;
      btn_in = 1'b1;
      run_len = 0;
      while (!instr_valid && run_len < 30) begin
         step();
         run_len++;
      end
      chk("rm_timeout", 32'(run_len < 30), 32'd1);
      chk("rm_word",    32'(instr_out),    32'hC3);
      step();
      chk("rm_count",   32'(step_count),   32'd1);
      btn_in = 1'b0;
      instr_ready = 1'b0;
      repeat (10) step();

      // 256 accepted handshakes wrap the counter.
      do_reset();
      instr_ready = 1'b1;
      hs_seen = 0;
      for (int i = 0; i < 256; i++) begin
         dip_in = W'($urandom);
         press(7, 7);
      end
      instr_ready = 1'b0;
      chk("wrap_handshakes", 32'(hs_seen),    32'd256);
      chk("wrap_count",      32'(step_count), 32'd0);

      // Random traffic with occasional resets.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         if ($urandom_range(0, 5) == 0) btn_in = ~btn_in;
         if ($urandom_range(0, 3) == 0) dip_in = W'($urandom);
         instr_ready = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
